// File: rtl/alu_pkg.sv
// Shared ALU definitions: the add/subtract op encoding and the signed saturation limits.
package alu_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    localparam int SAT_MAX_WIDTH = 64;

    // Largest positive two's-complement value of a w-bit word (0x7F..F).
    function automatic logic [SAT_MAX_WIDTH-1:0] sat_pos(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative two's-complement value of a w-bit word (0x80..0).
    function automatic logic [SAT_MAX_WIDTH-1:0] sat_neg(input int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/pipe_add_stage.sv
// One pipeline stage of pipe_add_sub: adds its CHUNK-bit slice with the incoming carry and
// registers the partial result alongside the still-unprocessed operand bits.
module pipe_add_stage #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    input  logic             v_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] bx_in,
    input  logic [WIDTH-1:0] s_in,
    input  logic             cin,
    output logic             v_out,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] bx_out,
    output logic [WIDTH-1:0] s_out,
    output logic             cout,
    output logic             c_msb
);

    localparam int LSB = IDX * CHUNK;

    logic [CHUNK-1:0] a_c;
    logic [CHUNK-1:0] b_c;
    logic [CHUNK:0]   sum;
    logic [WIDTH-1:0] s_next;
    logic             msb_cin;

    assign a_c = a_in[LSB +: CHUNK];
    assign b_c = bx_in[LSB +: CHUNK];
    assign sum = {1'b0, a_c} + {1'b0, b_c} + (CHUNK + 1)'(cin);

    // The carry into the chunk's top bit is recovered from that bit's sum and operands;
    // only the last stage's copy matters (it feeds the overflow flag).
    assign msb_cin = sum[CHUNK-1] ^ a_c[CHUNK-1] ^ b_c[CHUNK-1];

    // NOTE: every variable written in always_comb gets a full default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        s_next = s_in;
        s_next[LSB +: CHUNK] = sum[CHUNK-1:0];
    end

    // NOTE: the datapath registers are reset along with the valid bit so the visible outputs
    // read as zero during reset; the valid bit alone decides whether the data means anything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_out  <= 1'b0;
            a_out  <= '0;
            bx_out <= '0;
            s_out  <= '0;
            cout   <= 1'b0;
            c_msb  <= 1'b0;
        end else if (adv) begin
            // NOTE: non-blocking assignments for all clocked state, so every stage samples
            // its neighbour's pre-edge value regardless of evaluation order.
            v_out  <= v_in;
            a_out  <= a_in;
            bx_out <= bx_in;
            s_out  <= s_next;
            cout   <= sum[CHUNK];
            c_msb  <= msb_cin;
        end
    end

endmodule

// File: rtl/pipe_add_sub.sv
// Pipelined add/subtract, one CHUNK = WIDTH/STAGES bit slice per stage (WIDTH must be a multiple
// of STAGES). Define SATURATE_EN to clamp signed overflow instead of wrapping.
module pipe_add_sub
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow
);

    localparam int CHUNK = WIDTH / STAGES;

    logic             adv;
    logic [WIDTH-1:0] b_eff;

    logic             v_q   [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] bx_q  [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic             c_q   [STAGES];
    logic             cm_q  [STAGES];

    logic [WIDTH-1:0] wrapped;

    // The whole pipe moves as one; a stalled output freezes every stage.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Subtraction is a + ~b + 1, the +1 coming in as stage 0's carry.
    assign b_eff = (op_e'(op) == OP_SUB) ? ~b : b;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            pipe_add_stage #(.WIDTH(WIDTH), .CHUNK(CHUNK), .IDX(k)) u_stage (
                .clk    (clk),
                .rst_n  (rst_n),
                .adv    (adv),
                .v_in   (in_valid),
                .a_in   (a),
                .bx_in  (b_eff),
                .s_in   ({WIDTH{1'b0}}),
                .cin    (op),
                .v_out  (v_q[k]),
                .a_out  (a_q[k]),
                .bx_out (bx_q[k]),
                .s_out  (s_q[k]),
                .cout   (c_q[k]),
                .c_msb  (cm_q[k])
            );
        end else begin : g_next
            pipe_add_stage #(.WIDTH(WIDTH), .CHUNK(CHUNK), .IDX(k)) u_stage (
                .clk    (clk),
                .rst_n  (rst_n),
                .adv    (adv),
                .v_in   (v_q[k-1]),
                .a_in   (a_q[k-1]),
                .bx_in  (bx_q[k-1]),
                .s_in   (s_q[k-1]),
                .cin    (c_q[k-1]),
                .v_out  (v_q[k]),
                .a_out  (a_q[k]),
                .bx_out (bx_q[k]),
                .s_out  (s_q[k]),
                .cout   (c_q[k]),
                .c_msb  (cm_q[k])
            );
        end
    end

    // Outputs are pure functions of the last stage's registers, so they hold while stalled.
    assign out_valid = v_q[STAGES-1];
    assign wrapped   = s_q[STAGES-1];
    assign carry     = c_q[STAGES-1];
    assign overflow  = cm_q[STAGES-1] ^ c_q[STAGES-1];

`ifdef SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_pos(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_neg(WIDTH));

    // A positive overflow wraps to a negative-looking word, and vice versa.
    assign result = !overflow ? wrapped : (wrapped[WIDTH-1] ? SAT_MAX : SAT_MIN);
`else
    assign result = wrapped;
`endif

endmodule
